// File: rtl/sc_fifo_flags_if.sv
// rtl/sc_fifo_flags_if.sv - producer/consumer port bundle for sc_fifo_flags
interface sc_fifo_flags_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          write;
  logic [DW-1:0] din;
  logic          read;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_cnt;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  modport master (
    output write, din, read, clr_err,
    input  dout, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );

  modport slave (
    input  write, din, read, clr_err,
    output dout, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );
endinterface

// File: rtl/sc_fifo_flags.sv
// rtl/sc_fifo_flags.sv - single-clock FIFO with level flags and sticky errors
// Define SC_FIFO_FWFT_EN for the first-word-fall-through read path.
module sc_fifo_flags #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int AF_LVL = (1 << AW) - 1,
  parameter int AE_LVL = 1
) (
  input  logic           clk,
  input  logic           rst,
  sc_fifo_flags_if.slave bus
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_CNT   = (AW + 1)'(AE_LVL);

  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_af_chk
    $error("sc_fifo_flags: AF_LVL %0d outside 1..%0d", AF_LVL, DEPTH);
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_ae_chk
    $error("sc_fifo_flags: AE_LVL %0d outside 0..%0d", AE_LVL, DEPTH - 1);
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          full_r;
  logic          empty_r;
  logic          af_r;
  logic          ae_r;
  logic          ovf_r;
  logic          unf_r;
  logic          rd_acc;
  logic          wr_acc;

  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign rd_acc = bus.read & ~empty_r;
  assign wr_acc = bus.write & (~full_r | rd_acc);

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + (AW + 1)'(1);
      2'b01:   cnt_nxt = cnt - (AW + 1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt     <= cnt_nxt;
      full_r  <= (cnt_nxt == FULL_CNT);
      empty_r <= (cnt_nxt == '0);
      af_r    <= (cnt_nxt >= AF_CNT);
      ae_r    <= (cnt_nxt <= AE_CNT);
      // A fresh error in the clearing cycle keeps the flag set.
      ovf_r   <= (bus.write & ~wr_acc) | (ovf_r & ~bus.clr_err);
      unf_r   <= (bus.read & ~rd_acc) | (unf_r & ~bus.clr_err);
    end
  end

`ifdef SC_FIFO_FWFT_EN
  assign bus.dout = mem[rd_ptr];
`else
  logic [DW-1:0] dout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= '0;
    end else if (rd_acc) begin
      dout_r <= mem[rd_ptr];
    end
  end

  assign bus.dout = dout_r;
`endif

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.data_cnt     = cnt;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_sc_fifo_flags.sv
// tb/tb_sc_fifo_flags.sv - directed and random checks of sc_fifo_flags against a queue model
module tb_sc_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 7;
  localparam int AEL   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sc_fifo_flags_if #(.DW(DW), .AW(AW)) bus ();

  sc_fifo_flags #(.DW(DW), .AW(AW), .AF_LVL(AFL), .AE_LVL(AEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        vectors     = 0;
  int        miscompares = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_dout = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, compare every output.
  task automatic step(input logic w, input logic r, input logic c, input logic rs, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    bus.write   = w;
    bus.read    = r;
    bus.clr_err = c;
    bus.din     = d;
    rst         = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = 8'h00;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      m_ovf = (w && !wr_ok) || (m_ovf && !c);
      m_unf = (r && !rd_ok) || (m_unf && !c);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    chk("data_cnt", 32'(bus.data_cnt), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AFL));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AEL));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
`ifdef SC_FIFO_FWFT_EN
    if (q.size() > 0) chk("dout_fwft", 32'(bus.dout), 32'(q[0]));
`else
    chk("dout", 32'(bus.dout), 32'(m_dout));
`endif
  endtask

  initial begin
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.clr_err = 1'b0;
    bus.din     = '0;

    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 1, 1, 8'hEE);

    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 8'(i * 8'h11));

    step(1, 0, 0, 0, 8'h99);
    step(0, 0, 1, 0, 8'h00);
    step(1, 0, 1, 0, 8'hAA);
    step(0, 0, 1, 0, 8'h00);

    step(1, 1, 0, 0, 8'hBB);

    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);

    step(1, 1, 0, 0, 8'hCC);
    step(0, 0, 1, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'($urandom));
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
    end

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'($urandom));
    step(1, 1, 0, 1, 8'h5A);
    step(1, 0, 0, 0, 8'hA5);
    step(1, 0, 0, 0, 8'h3C);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 199) == 0),
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
